// File: rtl/noc_mem_resp_ni.sv
// Memory-side NoC network interface: AXI4-stream requests in, fixed-latency SRAM port, responses back to requester.
// Define NOC_RESP_WACK_EN to acknowledge each write packet with a response beat; otherwise writes are posted.
module noc_mem_resp_ni #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DX_W   = 2,
  parameter int DY_W   = 2,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0,
  localparam int STRB_W  = DATA_W / 8,
  localparam int TUSER_W = 2 * (DX_W + DY_W) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic [STRB_W-1:0]  s_tstrb,
  input  logic [STRB_W-1:0]  s_tkeep,
  input  logic               s_tlast,
  input  logic [ID_W-1:0]    s_tid,
  input  logic [ADDR_W-1:0]  s_tdest,
  input  logic [TUSER_W-1:0] s_tuser,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [DATA_W-1:0]  m_tdata,
  output logic [STRB_W-1:0]  m_tstrb,
  output logic [STRB_W-1:0]  m_tkeep,
  output logic               m_tlast,
  output logic [ID_W-1:0]    m_tid,
  output logic [ADDR_W-1:0]  m_tdest,
  output logic [TUSER_W-1:0] m_tuser,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [STRB_W-1:0]  mem_wstrb,
  input  logic [DATA_W-1:0]  mem_rdata
);
  localparam int XY_W   = DX_W + DY_W;
  localparam int WE_BIT = XY_W;

`ifdef NOC_RESP_WACK_EN
  typedef enum logic [2:0] {IDLE, WR, WR_ACK, RD_REQ, RD_WAIT, RD_RSP} state_t;
  localparam state_t WR_DONE = WR_ACK;
`else
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_RSP} state_t;
  localparam state_t WR_DONE = IDLE;
`endif

  state_t       state_q, state_d;
  logic         wr_fire, rd_issue;
  logic [15:0]  beat_cnt, beat_inc;
  logic [7:0]   len;

  // The request's destination field addresses this tile and is not needed downstream.
  logic unused_dst;
  assign unused_dst = ^s_tuser[XY_W-1:0];

  assign beat_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 16'd1;

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    s_tready = 1'b0;
    wr_fire  = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        s_tready = rst_n;
        if (s_tvalid && rst_n) begin
          if (s_tuser[WE_BIT]) begin
            wr_fire = 1'b1;
            state_d = s_tlast ? WR_DONE : WR;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WR: begin
        s_tready = rst_n;
        if (s_tvalid && rst_n) begin
          wr_fire = 1'b1;
          if (s_tlast) state_d = WR_DONE;
        end
      end
`ifdef NOC_RESP_WACK_EN
      WR_ACK:  if (m_tready) state_d = IDLE;
`endif
      RD_REQ: begin
        rd_issue = rst_n;
        state_d  = RD_WAIT;
      end
      RD_WAIT: state_d = RD_RSP;
      RD_RSP:  if (m_tready) state_d = m_tlast ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  // Memory port is driven straight from the accepted beat; idle fields read as zero.
  always_comb begin
    mem_req   = wr_fire | rd_issue;
    mem_we    = wr_fire;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (mem_req) mem_addr = (state_q == IDLE) ? s_tdest : m_tdest + ADDR_W'(beat_cnt);
    if (wr_fire) begin
      mem_wdata = s_tdata;
      mem_wstrb = s_tstrb & s_tkeep;
    end
  end

  // Response sideband equals the request's latched fields, so they double as the request context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
      m_tdest  <= '0;
      m_tuser  <= '0;
      beat_cnt <= '0;
      len      <= '0;
    end else begin
      if (state_q == IDLE && s_tvalid) begin
        m_tid   <= s_tid;
        m_tdest <= s_tdest;
        m_tuser <= {DY_W'(CUR_Y), DX_W'(CUR_X), 1'b0, s_tuser[TUSER_W-1 -: XY_W]};
        m_tstrb <= '1;
        m_tkeep <= '1;
        if (s_tuser[WE_BIT]) begin
          beat_cnt <= 16'd1;
        end else begin
          beat_cnt <= '0;
          len      <= s_tdata[7:0];
        end
      end
      if (state_q == WR && wr_fire) beat_cnt <= beat_inc;
`ifdef NOC_RESP_WACK_EN
      if (wr_fire && s_tlast) begin
        m_tvalid <= 1'b1;
        m_tlast  <= 1'b1;
        m_tdata  <= DATA_W'((state_q == IDLE) ? 16'd1 : beat_inc);
      end
      if (state_q == WR_ACK && m_tready) m_tvalid <= 1'b0;
`endif
      if (state_q == RD_WAIT) begin
        m_tvalid <= 1'b1;
        m_tdata  <= mem_rdata;
        m_tlast  <= (beat_cnt[8:0] == {1'b0, len});
      end
      if (state_q == RD_RSP && m_tready) begin
        m_tvalid <= 1'b0;
        if (!m_tlast) beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule
